// File: rtl/usart_cmd_pkg.sv
// Shared definitions for the USART command decoder: opcodes, frame field
// positions, FSM state encoding and the frame checksum helper.
package usart_cmd_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  localparam logic [3:0] OP_SET_DUTY = 4'd1;
  localparam logic [3:0] OP_SET_DIR  = 4'd2;
  localparam logic [3:0] OP_ENABLE   = 4'd3;
  localparam logic [3:0] OP_BRAKE    = 4'd4;

  localparam int HDR_MSB  = 31;
  localparam int HDR_LSB  = 24;
  localparam int OP_MSB   = 23;
  localparam int OP_LSB   = 20;
  localparam int ARG_MSB  = 19;
  localparam int ARG_LSB  = 8;
  localparam int CSUM_MSB = 7;
  localparam int CSUM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_APPLY,
    ST_ERR,
    ST_RELEASE,
    ST_WAIT_LOW
  } state_t;

  // Checksum covers the three upper bytes of the received word.
  function automatic logic [7:0] frame_csum(input logic [31:0] word);
    return word[31:24] ^ word[23:16] ^ word[15:8];
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// PWM duty ramp: a RAMP_DIV prescaler moves duty_out toward target by at most
// `step` per tick, clamping on the target so it never overshoots or wraps.
module duty_ramp #(
  parameter int RAMP_DIV = 1000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [11:0] target,
  input  logic [11:0] step,
  output logic [11:0] duty_out,
  output logic        duty_zero
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [11:0]      duty_next;

  assign tick      = (div_cnt == CNT_W'(RAMP_DIV - 1));
  assign duty_zero = (duty_out == 12'd0);

  always_comb begin
    // NOTE: default assignment first so no path leaves duty_next unassigned (no latch).
    duty_next = duty_out;
    if (target > duty_out) begin
      duty_next = ((target - duty_out) > step) ? duty_out + step : target;
    end else if (target < duty_out) begin
      duty_next = ((duty_out - target) > step) ? duty_out - step : target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      div_cnt  <= '0;
      duty_out <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) duty_out <= duty_next;
    end
  end

endmodule

// File: rtl/usart_cmd_decoder.sv
// Frame decoder between the USART receiver and the BLDC PWM control registers.
// Optional receive watchdog enabled by defining USART_CMD_WDOG_EN.
module usart_cmd_decoder
  import usart_cmd_pkg::*;
#(
  parameter int          RAMP_DIV    = 1000,
  parameter int          RAMP_STEP   = 16,
  parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
  parameter int          WDOG_CYCLES = 5000000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] data_rx,
  input  logic        data_ready,
  input  logic        parity_err,
  output logic        rec_clr,
  output logic [11:0] duty_out,
  output logic        dir_out,
  output logic        en_out,
  output logic        brake_out,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  state_t      state;
  logic        sync1, sync2, sync2_q;
  logic        ready_rise;
  logic [31:0] word_q;
  logic        par_q;
  logic [11:0] duty_set;
  logic        dir_req, dir_pend;
  logic        duty_zero;
  logic        frame_bad;
  logic        wdog_fire;
  logic [11:0] ramp_target;

  logic [7:0]  hdr_f, csum_f;
  logic [3:0]  opcode_f;
  logic [11:0] arg_f;

  // data_ready may be asynchronous: two sync flops plus one for edge detect.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) {sync2_q, sync2, sync1} <= 3'b000;
    else     {sync2_q, sync2, sync1} <= {sync2, sync1, data_ready};
  end
  assign ready_rise = sync2 & ~sync2_q;

  assign hdr_f    = word_q[HDR_MSB:HDR_LSB];
  assign opcode_f = word_q[OP_MSB:OP_LSB];
  assign arg_f    = word_q[ARG_MSB:ARG_LSB];
  assign csum_f   = word_q[CSUM_MSB:CSUM_LSB];
  assign frame_bad = par_q || (hdr_f != HEADER) || (csum_f != frame_csum(word_q))
                  || (opcode_f < OP_SET_DUTY) || (opcode_f > OP_BRAKE);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      par_q     <= 1'b0;
      duty_set  <= '0;
      dir_req   <= 1'b0;
      en_out    <= 1'b0;
      brake_out <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rec_clr   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rec_clr   <= 1'b0;
      case (state)
        ST_IDLE: if (ready_rise) begin
          word_q <= data_rx;
          par_q  <= parity_err;
          state  <= ST_CHECK;
        end
        ST_CHECK: state <= frame_bad ? ST_ERR : ST_APPLY;
        ST_APPLY: begin
          case (opcode_f)
            OP_SET_DUTY: duty_set  <= arg_f;
            OP_SET_DIR:  dir_req   <= arg_f[0];
            OP_ENABLE:   en_out    <= arg_f[0];
            OP_BRAKE:    brake_out <= arg_f[0];
            default: ;
          endcase
          frame_ok <= 1'b1;
          state    <= ST_RELEASE;
        end
        ST_ERR: begin
          frame_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          rec_clr <= 1'b1;
          state   <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: if (!sync2) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (wdog_fire) begin
        en_out    <= 1'b0;
        frame_err <= 1'b1;
      end
    end
  end

  // Direction only flips once the ramp has brought the motor to zero duty.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      dir_out  <= 1'b0;
      dir_pend <= 1'b0;
    end else if (dir_pend && duty_zero) begin
      dir_out  <= dir_req;
      dir_pend <= 1'b0;
    end else if (dir_req != dir_out) begin
      dir_pend <= 1'b1;
    end
  end

  assign ramp_target = (!en_out || brake_out || dir_pend || (dir_req != dir_out))
                     ? 12'd0 : duty_set;

  duty_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
    .CLK       (CLK),
    .CLR       (CLR),
    .target    (ramp_target),
    .step      (12'(RAMP_STEP)),
    .duty_out  (duty_out),
    .duty_zero (duty_zero)
  );

`ifdef USART_CMD_WDOG_EN
  logic [31:0] wdog_cnt;

  // Counter idles at 0 until the first applied frame arms it.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)                    wdog_cnt <= '0;
    else if (state == ST_APPLY) wdog_cnt <= 32'(WDOG_CYCLES);
    else if (wdog_cnt != '0)    wdog_cnt <= wdog_cnt - 32'd1;
  end
  assign wdog_fire = (wdog_cnt == 32'd1) && (state != ST_APPLY);
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_fire   = 1'b0;
`endif

endmodule
